// File: rtl/ahb_slv_fifo_ctrl_pkg.sv
// Shared helpers for the XSPI AHB slave FIFO controller.
package xspi_fifo_pkg;

    // Advance a pointer by one, wrapping to zero after the last valid entry.
    // DEPTH need not be a power of two, so plain binary overflow is not enough.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    // Occupancy counter width: one extra bit so a full FIFO (DEPTH entries) fits.
    function automatic int unsigned level_width(input int unsigned ptr_width);
        return ptr_width + 1;
    endfunction

endpackage

// File: rtl/ahb_slv_fifo_ctrl_if.sv
// Producer/consumer side of the FIFO controller: handshakes, status and errors.
interface ahb_slv_fifo_ctrl_if #(
    parameter int unsigned PTR_WIDTH  = 3,
    parameter int unsigned DATA_WIDTH = 39
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic [PTR_WIDTH:0]    level;
    logic                  flush;
    logic                  ovf;
    logic                  udf;
    logic                  clr_err;

    modport master (
        output push, push_data, pop, flush, clr_err,
        input  pop_data, pop_valid, full, empty, almost_full, level, ovf, udf
    );

    modport slave (
        input  push, push_data, pop, flush, clr_err,
        output pop_data, pop_valid, full, empty, almost_full, level, ovf, udf
    );
endinterface

// File: rtl/ahb_slv_fifo_ptr.sv
// FIFO pointer register with wrap at DEPTH, increment enable and synchronous clear.
module ahb_slv_fifo_ptr
    import xspi_fifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH = 3,
    parameter int unsigned DEPTH     = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [PTR_WIDTH-1:0] ptr_o
);
    logic [PTR_WIDTH-1:0] ptr_q;
    logic [PTR_WIDTH-1:0] ptr_d;

    // Next pointer: clear has priority over increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = PTR_WIDTH'(ptr_inc(32'(ptr_q), DEPTH));
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/ahb_slv_fifo_ctrl.sv
// FIFO controller for the XSPI AHB slave buffers: pointers, occupancy, flags
// and sticky errors, driving an external 1W/1R memory with registered read.
module ahb_slv_fifo_ctrl
    import xspi_fifo_pkg::*;
#(
    parameter int unsigned PTR_WIDTH    = 3,
    parameter int unsigned DATA_WIDTH   = 39,
    parameter int unsigned DEPTH        = 7,
    parameter int unsigned AFULL_THRESH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ahb_slv_fifo_ctrl_if.slave    bus,
    output logic [PTR_WIDTH-1:0]  mem_waddr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [PTR_WIDTH-1:0]  mem_raddr,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int unsigned      LVL_W   = level_width(PTR_WIDTH);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_L = LVL_W'(AFULL_THRESH);

    logic [PTR_WIDTH-1:0] wptr;
    logic [PTR_WIDTH-1:0] rptr;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 pop_valid_q;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 full, empty;
    logic                 push_acc, pop_acc;

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);

    // Accept decisions and combinational memory port drive.
    always_comb begin
        push_acc  = bus.push & ~full  & ~bus.flush;
        pop_acc   = bus.pop  & ~empty & ~bus.flush;
        mem_wen   = push_acc;
        mem_waddr = wptr;
        mem_wdata = bus.push_data;
        mem_ren   = pop_acc;
        mem_raddr = rptr;
    end

    ahb_slv_fifo_ptr #(.PTR_WIDTH(PTR_WIDTH), .DEPTH(DEPTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.flush),
        .inc_i (push_acc),
        .ptr_o (wptr)
    );

    ahb_slv_fifo_ptr #(.PTR_WIDTH(PTR_WIDTH), .DEPTH(DEPTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.flush),
        .inc_i (pop_acc),
        .ptr_o (rptr)
    );

    // Next occupancy and sticky error flags; a set in the same cycle beats clr_err.
    always_comb begin
        level_d = level_q;
        if (bus.flush) begin
            level_d = '0;
        end else if (push_acc && !pop_acc) begin
            level_d = level_q + 1'b1;
        end else if (pop_acc && !push_acc) begin
            level_d = level_q - 1'b1;
        end

        ovf_d = ovf_q;
        if (bus.push && full && !bus.flush) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end

        udf_d = udf_q;
        if (bus.pop && empty && !bus.flush) begin
            udf_d = 1'b1;
        end else if (bus.clr_err) begin
            udf_d = 1'b0;
        end
    end

    // State registers; pop_valid tracks the memory's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            level_q     <= level_d;
            pop_valid_q <= pop_acc;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign bus.pop_data    = mem_rdata;
    assign bus.pop_valid   = pop_valid_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (level_q >= AFULL_L);
    assign bus.level       = level_q;
    assign bus.ovf         = ovf_q;
    assign bus.udf         = udf_q;
endmodule

// File: tb/tb_ahb_slv_fifo_ctrl.sv
// Self-checking bench for ahb_slv_fifo_ctrl: directed test-plan steps followed by
// random traffic, all compared against a queue-based reference model.
module tb_ahb_slv_fifo_ctrl;
    localparam int unsigned PW    = 3;
    localparam int unsigned DW    = 39;
    localparam int unsigned DEPTH = 7;
    localparam int unsigned AFULL = 5;

    logic clk;
    logic rst_n;
    logic [PW-1:0] mem_waddr, mem_raddr;
    logic          mem_wen, mem_ren;
    logic [DW-1:0] mem_wdata, mem_rdata;

    ahb_slv_fifo_ctrl_if #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    ahb_slv_fifo_ctrl #(
        .PTR_WIDTH    (PW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_waddr (mem_waddr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata)
    );

    // Attached memory macro: synchronous write, registered read.
    logic [DW-1:0] mem [0:(1<<PW)-1];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    bit            ovf_m, udf_m, pv_m;
    logic [DW-1:0] pd_m;
    int unsigned   wcnt, rcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input bit clr_errs);
        q.delete();
        pv_m = 0;
        wcnt = 0;
        rcnt = 0;
        if (clr_errs) begin
            ovf_m = 0;
            udf_m = 0;
        end
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the model.
    task automatic step(input logic ps, input logic [DW-1:0] d, input logic pp,
                        input logic fl, input logic ce);
        bit pa, qa;
        int unsigned n;
        @(negedge clk);
        bus.push = ps; bus.push_data = d; bus.pop = pp; bus.flush = fl; bus.clr_err = ce;
        #1;
        n  = q.size();
        pa = ps && (n != DEPTH) && !fl;
        qa = pp && (n != 0) && !fl;
        chk("level", bus.level, n);
        chk("full", bus.full, n == DEPTH);
        chk("empty", bus.empty, n == 0);
        chk("almost_full", bus.almost_full, n >= AFULL);
        chk("ovf", bus.ovf, ovf_m);
        chk("udf", bus.udf, udf_m);
        chk("pop_valid", bus.pop_valid, pv_m);
        if (pv_m) chk("pop_data", bus.pop_data, pd_m);
        chk("mem_wen", mem_wen, pa);
        chk("mem_ren", mem_ren, qa);
        if (pa) begin
            chk("mem_waddr", mem_waddr, wcnt % DEPTH);
            chk("mem_wdata", mem_wdata, d);
        end
        if (qa) chk("mem_raddr", mem_raddr, rcnt % DEPTH);

        if (ps && n == DEPTH && !fl) ovf_m = 1;
        else if (ce) ovf_m = 0;
        if (pp && n == 0 && !fl) udf_m = 1;
        else if (ce) udf_m = 0;

        if (fl) begin
            model_clear(0);
        end else begin
            pv_m = qa;
            if (qa) begin
                pd_m = q.pop_front();
                rcnt++;
            end
            if (pa) begin
                q.push_back(d);
                wcnt++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_empty"}, bus.empty, 1);
        chk({tag, "_full"}, bus.full, 0);
        chk({tag, "_afull"}, bus.almost_full, 0);
        chk({tag, "_pop_valid"}, bus.pop_valid, 0);
        chk({tag, "_ovf"}, bus.ovf, 0);
        chk({tag, "_udf"}, bus.udf, 0);
        chk({tag, "_mem_wen"}, mem_wen, 0);
        chk({tag, "_mem_ren"}, mem_ren, 0);
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0);
    endtask

    logic [63:0]   rnd;
    logic [DW-1:0] rd;

    initial begin
        rst_n = 1'b0;
        bus.push = 0; bus.push_data = '0; bus.pop = 0; bus.flush = 0; bus.clr_err = 0;
        model_clear(1);
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 1..7, then drain in order
        for (int i = 1; i <= 7; i++) step(1, DW'(i), 0, 0, 0);
        idle();
        for (int i = 0; i < 7; i++) step(0, '0, 1, 0, 0);
        idle();

        // Overflow when full, then clear
        for (int i = 1; i <= 7; i++) step(1, DW'(i + 16), 0, 0, 0);
        step(1, DW'(8), 0, 0, 0);
        idle();
        step(0, '0, 0, 0, 1);
        idle();

        // Drain, underflow when empty, then clear
        for (int i = 0; i < 7; i++) step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        idle();
        step(0, '0, 0, 0, 1);

        // Steady push+pop at level 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1, DW'(32'h40 + i), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, DW'(32'h100 + i), 1, 0, 0);
        idle();
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);

        // Push+pop when empty, then push+pop when full
        step(1, DW'(32'h200), 1, 0, 0);
        idle();
        for (int i = 1; i < 7; i++) step(1, DW'(32'h200 + i), 0, 0, 0);
        step(1, DW'(32'h2ff), 1, 0, 0);
        idle();
        step(0, '0, 0, 0, 1);

        // Down to level 4, then flush together with push and pop
        step(0, '0, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        step(1, DW'(32'h300), 1, 1, 0);
        idle();
        step(1, DW'(32'h301), 0, 0, 0);
        step(0, '0, 1, 0, 0);
        idle();

        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                @(negedge clk);
                #2;
                bus.push = 0; bus.pop = 0; bus.flush = 0; bus.clr_err = 0;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midreset");
                model_clear(1);
                @(negedge clk);
                rst_n = 1'b1;
            end
            rnd = {$urandom(), $urandom()};
            rd  = rnd[DW-1:0];
            step(($urandom % 3) != 0, rd, ($urandom % 2) != 0,
                 ($urandom % 25) == 0, ($urandom % 12) == 0);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
